// File: rtl/xor_stream_descrambler_if.sv
// rtl/xor_stream_descrambler_if.sv - input/output stream bundle for the XOR keystream descrambler
//
// Purpose: carries both valid/ready streams of the descrambler in one bundle.
//   in_valid/in_data/in_ready     : scrambled words from the link receive buffer
//   out_valid/out_data/out_ready  : descrambled words to the downstream consumer
//   in_par/out_par_err            : only present when XOR_DESCR_PARITY_EN is defined
// Modports:
//   slave  : descrambler side (consumes in_*, produces out_*)
//   master : environment side (produces in_*, consumes out_*)
interface xor_stream_descrambler_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic [N-1:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [N-1:0] out_data;
    logic         out_ready;
`ifdef XOR_DESCR_PARITY_EN
    logic         in_par;
    logic         out_par_err;
`endif

`ifdef XOR_DESCR_PARITY_EN
    modport slave (
        input  in_valid, in_data, in_par, out_ready,
        output in_ready, out_valid, out_data, out_par_err
    );
    modport master (
        output in_valid, in_data, in_par, out_ready,
        input  in_ready, out_valid, out_data, out_par_err
    );
`else
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
`endif
endinterface

// File: rtl/xor_stream_descrambler.sv
// rtl/xor_stream_descrambler.sv - receive-side LFSR XOR keystream descrambler
//
// Purpose: XORs each accepted N-bit word with the low N bits of a 32-bit
// Fibonacci LFSR keystream; the LFSR steps once per accepted word. The result
// is held in a one-word output register (1-cycle latency, full throughput).
// Optional per-frame resync reloads the LFSR from the stored seed every
// FRAME_LEN accepted words (FRAME_LEN=0 disables it).
// Optional feature macro: XOR_DESCR_PARITY_EN (adds in_par / out_par_err).
// Ports:
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   seed_load  : one-cycle pulse capturing seed
//   seed       : 32-bit keystream seed (0 is treated as 1)
//   s          : stream bundle (in_valid/in_data/in_ready, out_valid/out_data/out_ready)
//   frame_done : pulses while the last word of a frame is first presented
//   seeded     : keystream initialised
module xor_stream_descrambler #(
    parameter int          N         = 32,
    parameter logic [31:0] TAPS      = 32'h8020_0003,
    parameter int unsigned FRAME_LEN = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      seed_load,
    input  logic [31:0]               seed,
    xor_stream_descrambler_if.slave   s,
    output logic                      frame_done,
    output logic                      seeded
);

    typedef enum logic {UNSEEDED = 1'b0, RUN = 1'b1} state_t;

    localparam logic [31:0] FRAME_LAST = (FRAME_LEN > 0) ? 32'(FRAME_LEN - 1) : 32'd0;

    state_t       state_q, state_d;
    logic [31:0]  lfsr_q, lfsr_d;
    logic [31:0]  seed_q, seed_d;
    logic [31:0]  frame_cnt_q, frame_cnt_d;
    logic         out_valid_q, out_valid_d;
    logic [N-1:0] out_data_q, out_data_d;
    logic         frame_done_q, frame_done_d;
`ifdef XOR_DESCR_PARITY_EN
    logic         par_err_q, par_err_d;
`endif

    logic         in_ready;
    logic         accept;
    logic         frame_hit;
    logic [31:0]  seed_eff;
    logic [31:0]  lfsr_step;

    // seed_load takes priority over data: no word is accepted in a reseed cycle.
    assign in_ready  = (state_q == RUN) && !seed_load && (!out_valid_q || s.out_ready);
    assign accept    = s.in_valid && in_ready;
    // A zero seed would lock the LFSR at zero forever.
    assign seed_eff  = (seed == 32'd0) ? 32'd1 : seed;
    assign lfsr_step = {lfsr_q[30:0], ^(lfsr_q & TAPS)};
    assign frame_hit = (FRAME_LEN != 0) && (frame_cnt_q == FRAME_LAST);

    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        seed_d       = seed_q;
        frame_cnt_d  = frame_cnt_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        frame_done_d = 1'b0;
`ifdef XOR_DESCR_PARITY_EN
        par_err_d    = par_err_q;
`endif

        case (state_q)
            UNSEEDED: if (seed_load) state_d = RUN;
            RUN:      state_d = RUN;
            default:  state_d = UNSEEDED;
        endcase

        // Held word leaves when the consumer takes it; a new accept refills below.
        if (out_valid_q && s.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (seed_load) begin
            seed_d      = seed_eff;
            lfsr_d      = seed_eff;
            frame_cnt_d = 32'd0;
        end else if (accept) begin
            out_data_d  = s.in_data ^ lfsr_q[N-1:0];
            out_valid_d = 1'b1;
`ifdef XOR_DESCR_PARITY_EN
            par_err_d   = ^{s.in_data, s.in_par};
`endif
            if (frame_hit) begin
                // Last word of the frame: restart the keystream for the next frame.
                lfsr_d       = seed_q;
                frame_cnt_d  = 32'd0;
                frame_done_d = 1'b1;
            end else begin
                lfsr_d       = lfsr_step;
                frame_cnt_d  = frame_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= UNSEEDED;
            lfsr_q       <= 32'd0;
            seed_q       <= 32'd0;
            frame_cnt_q  <= 32'd0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            frame_done_q <= 1'b0;
`ifdef XOR_DESCR_PARITY_EN
            par_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            seed_q       <= seed_d;
            frame_cnt_q  <= frame_cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            frame_done_q <= frame_done_d;
`ifdef XOR_DESCR_PARITY_EN
            par_err_q    <= par_err_d;
`endif
        end
    end

    assign s.in_ready  = in_ready;
    assign s.out_valid = out_valid_q;
    assign s.out_data  = out_data_q;
`ifdef XOR_DESCR_PARITY_EN
    assign s.out_par_err = par_err_q;
`endif
    assign frame_done  = frame_done_q;
    assign seeded      = (state_q == RUN);

endmodule
